fu_issue_ctrl: RTL
==================

FU_ISSUE_CTRL -- requirements
Module: fu_issue_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, sets the number of queued operations (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  upstream offers an operation.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 in_instr  input  8  one-hot-priority instruction word.
REQ-007 in_a, in_b, in_c  input  8 each  operands.
REQ-008 fu_instr  output  8  instruction driven to the functional unit.
REQ-009 fu_a, fu_b, fu_c  output  8 each  operands driven to the functional unit.
REQ-010 fu_sel  output  3  encoded opcode driven to the functional unit select input.
REQ-011 fu_f  input  8  functional-unit result, combinational from fu_* outputs.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 out_data  output  8  captured result.
REQ-015 out_op  output  3  encoded opcode of the captured result.
REQ-016 illegal_cnt  output  8  count of dropped all-zero instructions.

Function
REQ-017 Accept = in_valid & in_ready; accepted {instr,a,b,c} SHALL be pushed into a DEPTH-entry FIFO in order.
REQ-018 in_ready SHALL be 1 exactly when the FIFO is not full, from registered count only; a pop in the same cycle does not raise it.
REQ-019 Opcode encode: highest set bit index of instr (bit7 -> 3'b111 ... bit0 -> 3'b000).
REQ-020 FSM states IDLE, ISSUE, HOLD; IDLE with FIFO non-empty pops the head.
REQ-021 Popped entry with instr == 8'h00 SHALL be discarded, illegal_cnt incremented (saturate at 255), FSM stays IDLE.
REQ-022 Popped legal entry SHALL load fu_instr/fu_a/fu_b/fu_c and fu_sel = encoded opcode, FSM -> ISSUE.
REQ-023 ISSUE lasts exactly one cycle; at its end fu_f -> out_data, fu_sel -> out_op, out_valid <= 1, FSM -> HOLD.
REQ-024 Latency: accept at edge k into empty idle block -> out_valid high after edge k+2.
REQ-025 HOLD: out_data, out_op, out_valid stable until out_valid & out_ready.
REQ-026 On HOLD handshake: FIFO non-empty -> pop and go to ISSUE (legal) or IDLE (illegal, counted); empty -> IDLE; out_valid drops unless a new result is captured.
REQ-027 fu_* outputs SHALL hold last issued values between operations.
REQ-028 Simultaneous push and pop with FIFO non-full: both occur, count unchanged.
REQ-029 Throughput: one result per 2 cycles when out_ready held 1.

Reset
REQ-030 rst_n low SHALL asynchronously force FSM IDLE, FIFO empty, out_valid 0, out_data/out_op 0, fu_* 0, illegal_cnt 0; in-flight and queued operations are discarded.
REQ-031 in_ready SHALL read 1 in the first cycle after rst_n deasserts.

Structure
REQ-032 Package fu_pkg SHALL hold the FSM state enum, opcode width/constants and the priority-encode function.
REQ-033 FIFO storage SHALL be a sub-module fu_fifo (synchronous, DEPTH-parameterised, full/empty/count).

Verification (bench FU model: fu_f = fu_a + fu_b)
REQ-034 Push instr 8'h01, a=3, b=4 into idle block -> out_valid after 2 edges, out_data 7, out_op 000, fu_sel 000.
REQ-035 Push instr 8'hFF, a=10, b=20 -> out_op 111, fu_sel 111, out_data 30.
REQ-036 out_ready 0, push 6 ops back-to-back -> one in HOLD, 4 queued, in_ready 0 after fifth accept; release out_ready -> 5 results in push order.
REQ-037 Push instr 8'h00 then 8'h04 -> illegal_cnt 1, only one result, out_op 010.
REQ-038 Assert rst_n low during HOLD with 3 queued -> out_valid 0 immediately, in_ready 1 after release, no stale results emerge.

Source files
------------

// File: rtl/fu_pkg.sv
// -----------------------------------------------------------------------------
// fu_pkg
// Shared definitions for the functional-unit issue controller:
//   - data/opcode widths and opcode constants
//   - issue FSM state encoding
//   - queued operation record
//   - priority encoder mapping an instruction word to its 3-bit opcode
// -----------------------------------------------------------------------------
package fu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0]   OP_BIT0       = 3'b000;
    localparam logic [OP_W-1:0]   OP_BIT7       = 3'b111;
    localparam logic [DATA_W-1:0] INSTR_ILLEGAL = 8'h00;
    localparam logic [DATA_W-1:0] CNT_MAX       = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_HOLD  = 2'b10
    } fu_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] c;
    } fu_entry_t;

    // Highest set bit wins; scanning upward lets later (higher) bits override.
    // An all-zero word encodes as OP_BIT0 but is never issued.
    function automatic logic [OP_W-1:0] prio_encode(input logic [DATA_W-1:0] instr);
        logic [OP_W-1:0] enc;
        enc = OP_BIT0;
        for (int k = 0; k < DATA_W; k++) begin
            if (instr[k]) begin
                enc = OP_W'(k);
            end
        end
        return enc;
    endfunction

endpackage

// File: rtl/fu_fifo.sv
// -----------------------------------------------------------------------------
// fu_fifo
// Synchronous DEPTH-entry FIFO of fu_entry_t records (DEPTH a power of two).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, wr_data     write request and record (ignored when full)
//   pop               read request (ignored when empty); rd_data shows the head
//   full, empty       status decoded from the registered occupancy
//   count             registered occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fu_fifo
    import fu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fu_entry_t     wr_data,
    input  logic          pop,
    output fu_entry_t     rd_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    fu_entry_t     mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_s;
    logic          pop_s;

    assign full    = (count_r == CW'(DEPTH));
    assign empty   = (count_r == {CW{1'b0}});
    assign count   = count_r;
    assign rd_data = mem_r[rd_ptr_r];
    assign push_s  = push & ~full;
    assign pop_s   = pop & ~empty;

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{8'h00, 8'h00, 8'h00, 8'h00};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fu_issue_ctrl
// Queues operations, issues them one at a time to an external combinational
// functional unit, and holds each captured result until downstream takes it.
// All-zero instructions are discarded on pop and counted.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           upstream handshake
//   in_instr, in_a/b/c          operation offered upstream
//   fu_instr, fu_a/b/c, fu_sel  registered drive to the functional unit
//   fu_f                        functional-unit result (combinational from fu_*)
//   out_valid/out_ready         downstream handshake
//   out_data, out_op            captured result and its opcode
//   illegal_cnt                 saturating count of dropped all-zero instructions
// -----------------------------------------------------------------------------
module fu_issue_ctrl
    import fu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_c,
    output logic [DATA_W-1:0] fu_instr,
    output logic [DATA_W-1:0] fu_a,
    output logic [DATA_W-1:0] fu_b,
    output logic [DATA_W-1:0] fu_c,
    output logic [OP_W-1:0]   fu_sel,
    input  logic [DATA_W-1:0] fu_f,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OP_W-1:0]   out_op,
    output logic [DATA_W-1:0] illegal_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    fu_entry_t         in_entry_s;
    fu_entry_t         head_s;
    logic              full_s;
    logic              empty_s;
    logic [CW-1:0]     count_s;
    logic              push_s;
    logic              pop_s;
    logic              head_legal_s;

    fu_state_t         state_r;
    fu_state_t         state_next_s;
    logic              load_s;
    logic              drop_s;
    logic              capture_s;
    logic              release_s;

    logic [DATA_W-1:0] fu_instr_r;
    logic [DATA_W-1:0] fu_a_r;
    logic [DATA_W-1:0] fu_b_r;
    logic [DATA_W-1:0] fu_c_r;
    logic [OP_W-1:0]   fu_sel_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic [OP_W-1:0]   out_op_r;
    logic [DATA_W-1:0] illegal_cnt_r;

    assign in_entry_s   = '{in_instr, in_a, in_b, in_c};
    // Ready comes from the registered occupancy only, so a same-cycle pop
    // never opens a slot early.
    assign in_ready     = (count_s != CW'(DEPTH));
    assign push_s       = in_valid & ~full_s;
    assign head_legal_s = (head_s.instr != INSTR_ILLEGAL);

    fu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_s),
        .wr_data (in_entry_s),
        .pop     (pop_s),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s),
        .count   (count_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and datapath control. A pop happens from IDLE, or from HOLD
    // on the same edge the held result is taken, giving one result per two
    // cycles when downstream is always ready.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        load_s       = 1'b0;
        drop_s       = 1'b0;
        capture_s    = 1'b0;
        release_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s = 1'b1;
                    if (head_legal_s) begin
                        load_s       = 1'b1;
                        state_next_s = ST_ISSUE;
                    end else begin
                        drop_s       = 1'b1;
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                capture_s    = 1'b1;
                state_next_s = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_valid_r && out_ready) begin
                    release_s = 1'b1;
                    if (!empty_s) begin
                        pop_s = 1'b1;
                        if (head_legal_s) begin
                            load_s       = 1'b1;
                            state_next_s = ST_ISSUE;
                        end else begin
                            drop_s       = 1'b1;
                            state_next_s = ST_IDLE;
                        end
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Issue registers, result capture and illegal-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fu_instr_r    <= 8'h00;
            fu_a_r        <= 8'h00;
            fu_b_r        <= 8'h00;
            fu_c_r        <= 8'h00;
            fu_sel_r      <= OP_BIT0;
            out_valid_r   <= 1'b0;
            out_data_r    <= 8'h00;
            out_op_r      <= OP_BIT0;
            illegal_cnt_r <= 8'h00;
        end else begin
            if (load_s) begin
                fu_instr_r <= head_s.instr;
                fu_a_r     <= head_s.a;
                fu_b_r     <= head_s.b;
                fu_c_r     <= head_s.c;
                fu_sel_r   <= prio_encode(head_s.instr);
            end
            if (drop_s && (illegal_cnt_r != CNT_MAX)) begin
                illegal_cnt_r <= illegal_cnt_r + 8'd1;
            end
            if (capture_s) begin
                out_data_r  <= fu_f;
                out_op_r    <= fu_sel_r;
                out_valid_r <= 1'b1;
            end else if (release_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign fu_instr    = fu_instr_r;
    assign fu_a        = fu_a_r;
    assign fu_b        = fu_b_r;
    assign fu_c        = fu_c_r;
    assign fu_sel      = fu_sel_r;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_op      = out_op_r;
    assign illegal_cnt = illegal_cnt_r;

endmodule
